// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the writeback entry type used by the arbiter and its load queue.
// Holds no logic beyond a onehot helper for the pending-register mask.
package wb_arbiter_pkg;

  localparam int REG_AW   = 3;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[a] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// In-order load result FIFO; push/pop take effect on the clock edge, head is visible combinationally.
// Never overflows or underflows: a push when full or a pop when empty is ignored.
module wb_queue
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_dat,
  input  logic                     pop,
  output wb_entry_t                head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [NUM_REGS-1:0]      pend
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t           mem [DEPTH];
  logic [DEPTH-1:0]    slot_vld;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      slot_vld <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr           <= wr_ptr + 1'b1;
        slot_vld[wr_ptr] <= 1'b1;
      end
      // A pop never targets the slot being pushed: pushes only land in free slots.
      if (pop_ok) begin
        rd_ptr           <= rd_ptr + 1'b1;
        slot_vld[rd_ptr] <= 1'b0;
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i]) pend = pend | reg_onehot(mem[i].addr);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: ALU first, queued loads in order, direct load bypass when idle.
// One cycle accept-to-write; ld_rdy drops when the queue is full, alu_rdy drops when the head has starved.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int STARVE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_vld,
  output logic                 alu_rdy,
  input  logic [REG_AW-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_vld,
  output logic                 ld_rdy,
  input  logic [REG_AW-1:0]    ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 wr,
  output logic [REG_AW-1:0]    waddr,
  output logic [DATA_W-1:0]    wdata,
  output logic [NUM_REGS-1:0]  pend
);

  localparam logic [1:0] STARVE_MAX = 2'(STARVE);

  logic                     alu_acc;
  logic                     ld_acc;
  logic                     q_push;
  logic                     q_pop;
  logic                     bypass;
  logic                     q_full;
  logic                     q_empty;
  logic [$clog2(DEPTH):0]   q_count;
  wb_entry_t                q_head;
  wb_entry_t                sel;
  logic                     issue;
  logic [1:0]               starve_cnt;

  assign alu_rdy = (starve_cnt != STARVE_MAX);
  assign ld_rdy  = ~q_full;
  assign alu_acc = alu_vld & alu_rdy;
  assign ld_acc  = ld_vld & ld_rdy;

  assign q_pop   = ~alu_acc & ~q_empty;
  assign bypass  = ~alu_acc & q_empty & ld_acc;
  assign q_push  = ld_acc & ~bypass;

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_dat ('{addr: ld_addr, data: ld_data}),
    .pop      (q_pop),
    .head_dat (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count),
    .pend     (pend)
  );

  always_comb begin
    sel   = '{addr: alu_addr, data: alu_data};
    issue = 1'b0;
    if (alu_acc) begin
      issue = 1'b1;
    end else if (!q_empty) begin
      sel   = q_head;
      issue = 1'b1;
    end else if (ld_acc) begin
      sel   = '{addr: ld_addr, data: ld_data};
      issue = 1'b1;
    end
  end

  // Counts cycles the current head has been passed over by the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (q_empty || q_pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      wr <= issue;
      if (issue) begin
        waddr <= sel.addr;
        wdata <= sel.data;
      end
    end
  end

  a_count_in_range: assert property (@(posedge clk) disable iff (rst) q_count <= ($clog2(DEPTH)+1)'(DEPTH));

endmodule
